// File: rtl/dma_transfer_sequencer.sv
// DMA transfer sequencer: runs the HRQ/HLDA handshake and steps one transfer
// cycle per service through S0..S4. Optional READY wait state: DMA_SEQ_READY_EN.
module dma_transfer_sequencer #(
    parameter int NCH = 4
) (
    input  logic           Clock,
    input  logic           Reset_n,
    input  logic           ReqValid,
    input  logic [1:0]     ReqChannel,
    input  logic [5:0]     ModeIn,
    input  logic [7:0]     CommandIn,
    input  logic [NCH-1:0] TWCZero,
    input  logic           HLDA,
    input  logic           READY,
    input  logic           EOP_n,
    output logic           HRQ,
    output logic           AEN,
    output logic           ADSTB,
    output logic [NCH-1:0] DACK,
    output logic           MEMR_n,
    output logic           MEMW_n,
    output logic           IOR_n,
    output logic           IOW_n,
    output logic [NCH-1:0] TAREnable,
    output logic [NCH-1:0] TARLoad,
    output logic [NCH-1:0] TWCLoad,
    output logic [NCH-1:0] RollOverCheck,
    output logic           TCOut,
    output logic           Busy
);

    typedef enum logic [2:0] {
        ST_I, ST_0, ST_1, ST_2, ST_3, ST_4
`ifdef DMA_SEQ_READY_EN
        , ST_W
`endif
    } state_t;

    localparam logic [1:0] XM_DEMAND = 2'b00;
    localparam logic [1:0] XM_BLOCK  = 2'b10;
    localparam logic [1:0] TY_WRITE  = 2'b01;
    localparam logic [1:0] TY_READ   = 2'b10;
    localparam logic [NCH-1:0] ONE   = {{(NCH-1){1'b0}}, 1'b1};

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [1:0] xmode_q, xmode_d;
    logic [1:0] xtype_q, xtype_d;
    logic       tc;

    // Bits decoded by the datapath or not relevant to sequencing.
    logic unused_bits;
`ifdef DMA_SEQ_READY_EN
    assign unused_bits = ^{ModeIn[3:2], CommandIn[7:3], CommandIn[1:0]};
`else
    assign unused_bits = ^{ModeIn[3:2], CommandIn[7:3], CommandIn[1:0], READY};
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_I;
            ch_q    <= 2'd0;
            xmode_q <= 2'd0;
            xtype_q <= 2'd0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            xmode_q <= xmode_d;
            xtype_q <= xtype_d;
        end
    end

    // EOP_n only matters in S4; a pulse elsewhere is dropped.
    assign tc = (state_q == ST_4) && (TWCZero[ch_q] || !EOP_n);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        xmode_d = xmode_q;
        xtype_d = xtype_q;
        case (state_q)
            ST_I: begin
                if (ReqValid && !CommandIn[2]) begin
                    ch_d    = ReqChannel;
                    // Cascade sequences like single.
                    xmode_d = (ModeIn[5:4] == 2'b11) ? 2'b01 : ModeIn[5:4];
                    xtype_d = ModeIn[1:0];
                    state_d = ST_0;
                end
            end
            ST_0: begin
                if (CommandIn[2])  state_d = ST_I;
                else if (HLDA)     state_d = ST_1;
            end
            ST_1: state_d = ST_2;
            ST_2: state_d = ST_3;
`ifdef DMA_SEQ_READY_EN
            ST_3: state_d = READY ? ST_4 : ST_W;
            ST_W: if (READY) state_d = ST_4;
`else
            ST_3: state_d = ST_4;
`endif
            ST_4: begin
                if (!HLDA || tc)
                    state_d = ST_I;
                else if (xmode_q == XM_BLOCK)
                    state_d = ST_1;
                else if (xmode_q == XM_DEMAND && ReqValid && ReqChannel == ch_q)
                    state_d = ST_1;
                else
                    state_d = ST_I;
            end
            default: state_d = ST_I;
        endcase
    end

    logic in_xfer, addr_ph, ack_ph, rd_ph, wr_ph, ld_ph;
    logic [NCH-1:0] ch_oh;

    always_comb begin
        in_xfer = 1'b0;
        addr_ph = 1'b0;
        ack_ph  = 1'b0;
        rd_ph   = 1'b0;
        wr_ph   = 1'b0;
        ld_ph   = 1'b0;
        case (state_q)
            ST_1: begin in_xfer = 1'b1; addr_ph = 1'b1; end
            ST_2: begin in_xfer = 1'b1; addr_ph = 1'b1; ack_ph = 1'b1; rd_ph = 1'b1; end
            ST_3: begin in_xfer = 1'b1; addr_ph = 1'b1; ack_ph = 1'b1; rd_ph = 1'b1; wr_ph = 1'b1; end
`ifdef DMA_SEQ_READY_EN
            ST_W: begin in_xfer = 1'b1; addr_ph = 1'b1; ack_ph = 1'b1; rd_ph = 1'b1; wr_ph = 1'b1; end
`endif
            ST_4: begin in_xfer = 1'b1; ack_ph = 1'b1; ld_ph = 1'b1; end
            default: ;
        endcase
    end

    assign ch_oh         = ONE << ch_q;
    assign Busy          = (state_q != ST_I);
    assign HRQ           = Busy;
    assign AEN           = in_xfer;
    assign ADSTB         = (state_q == ST_1);
    assign DACK          = ack_ph  ? ch_oh : '0;
    assign TAREnable     = addr_ph ? ch_oh : '0;
    assign TARLoad       = ld_ph   ? ch_oh : '0;
    assign TWCLoad       = ld_ph   ? ch_oh : '0;
    assign RollOverCheck = ld_ph   ? ch_oh : '0;
    assign TCOut         = tc;
    assign MEMR_n        = !(rd_ph && xtype_q == TY_READ);
    assign IOR_n         = !(rd_ph && xtype_q == TY_WRITE);
    assign IOW_n         = !(wr_ph && xtype_q == TY_READ);
    assign MEMW_n        = !(wr_ph && xtype_q == TY_WRITE);

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Table-driven bench for dma_transfer_sequencer: per-cycle vectors with the
// expected state label, expected outputs queued on drive and popped at negedge.
module tb_dma_transfer_sequencer;

    localparam int PI = 0, P0 = 1, P1 = 2, P2 = 3, P3 = 4, P4 = 5, PW = 6;
    localparam logic [1:0] RD = 2'b10, WR = 2'b01, VF = 2'b00;
    localparam logic [5:0] M_SRD = 6'b010010, M_SWR = 6'b010001, M_BWR = 6'b100001;
    localparam logic [5:0] M_DRD = 6'b000010, M_BRD = 6'b100010, M_CVF = 6'b110000;

    logic       Clock = 1'b0, Reset_n = 1'b0;
    logic       ReqValid = 1'b0, HLDA = 1'b0, READY = 1'b1, EOP_n = 1'b1;
    logic [1:0] ReqChannel = 2'd0;
    logic [5:0] ModeIn = 6'd0;
    logic [7:0] CommandIn = 8'd0;
    logic [3:0] TWCZero = 4'd0;
    logic       HRQ, AEN, ADSTB, MEMR_n, MEMW_n, IOR_n, IOW_n, TCOut, Busy;
    logic [3:0] DACK, TAREnable, TARLoad, TWCLoad, RollOverCheck;

    dma_transfer_sequencer #(.NCH(4)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .ReqValid(ReqValid), .ReqChannel(ReqChannel),
        .ModeIn(ModeIn), .CommandIn(CommandIn), .TWCZero(TWCZero), .HLDA(HLDA),
        .READY(READY), .EOP_n(EOP_n), .HRQ(HRQ), .AEN(AEN), .ADSTB(ADSTB), .DACK(DACK),
        .MEMR_n(MEMR_n), .MEMW_n(MEMW_n), .IOR_n(IOR_n), .IOW_n(IOW_n),
        .TAREnable(TAREnable), .TARLoad(TARLoad), .TWCLoad(TWCLoad),
        .RollOverCheck(RollOverCheck), .TCOut(TCOut), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic rv; logic [1:0] rch; logic [5:0] mode; logic dis; logic [3:0] twcz;
        logic hlda; logic eop_n; logic rdy; int ph; logic [1:0] ech; logic [1:0] ety;
        logic tc; logic rst;
    } vec_t;

    typedef struct { logic [28:0] e; int idx; } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   checks = 0, failures = 0;

    task automatic v(input logic rv, input logic [1:0] rch, input logic [5:0] mode,
                     input logic dis, input logic [3:0] twcz, input logic hlda,
                     input logic eop_n, input logic rdy, input int ph,
                     input logic [1:0] ech, input logic [1:0] ety, input logic tc,
                     input logic rst);
        vec_t t;
        t.rv = rv; t.rch = rch; t.mode = mode; t.dis = dis; t.twcz = twcz;
        t.hlda = hlda; t.eop_n = eop_n; t.rdy = rdy; t.ph = ph; t.ech = ech;
        t.ety = ety; t.tc = tc; t.rst = rst;
        tbl.push_back(t);
    endtask

    // Expected bus/control outputs for a given sequencer state.
    function automatic logic [28:0] expv(input int ph, input logic [1:0] ch,
                                         input logic [1:0] ty, input logic tc);
        logic [3:0] oh, dk, te, ld;
        logic hrq, aen, adstb, busy, tco, rdp, wrp;
        oh    = 4'b0001 << ch;
        busy  = (ph != PI);
        hrq   = busy;
        aen   = (ph == P1 || ph == P2 || ph == P3 || ph == P4 || ph == PW);
        adstb = (ph == P1);
        dk    = (ph == P2 || ph == P3 || ph == PW || ph == P4) ? oh : 4'b0;
        te    = (ph == P1 || ph == P2 || ph == P3 || ph == PW) ? oh : 4'b0;
        ld    = (ph == P4) ? oh : 4'b0;
        tco   = (ph == P4) && tc;
        rdp   = (ph == P2 || ph == P3 || ph == PW);
        wrp   = (ph == P3 || ph == PW);
        return {hrq, aen, adstb, busy, tco,
                !(rdp && ty == RD), !(wrp && ty == WR), !(rdp && ty == WR), !(wrp && ty == RD),
                dk, te, ld, ld, ld};
    endfunction

    function automatic logic [28:0] actual();
        return {HRQ, AEN, ADSTB, Busy, TCOut, MEMR_n, MEMW_n, IOR_n, IOW_n,
                DACK, TAREnable, TARLoad, TWCLoad, RollOverCheck};
    endfunction

    task automatic check_pop(input logic [28:0] act);
        sb_t s;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=%h required=entry", act);
        end else begin
            s = sb.pop_front();
            if (act !== s.e) begin
                failures++;
                $display("FAIL vec%0d got=%h required=%h", s.idx, act, s.e);
            end
        end
    endtask

    initial begin
        sb_t s;
        // single read ch2, other channels' TWCZero set, inputs change mid-service
        v(1,2,M_SRD,0,4'b1011,0,1,1,PI,2,RD,0,0);
        v(0,0,6'd0 ,0,4'b1011,0,1,1,P0,2,RD,0,0);
        v(0,1,M_BWR,0,4'b1011,1,1,1,P0,2,RD,0,0);
        v(0,0,6'd0 ,0,4'b1011,1,1,1,P1,2,RD,0,0);
        v(0,0,6'd0 ,0,4'b1011,1,1,1,P2,2,RD,0,0);
        v(0,0,6'd0 ,0,4'b1011,1,1,1,P3,2,RD,0,0);
        v(0,0,6'd0 ,0,4'b1011,1,1,1,P4,2,RD,0,0);
        v(0,0,6'd0 ,0,4'b0000,1,1,1,PI,2,RD,0,0);
        v(0,0,6'd0 ,0,4'b0000,0,1,1,PI,2,RD,0,0);
        // block write ch0, TC on 3rd S4
        v(1,0,M_BWR,0,0,0,1,1,PI,0,WR,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P0,0,WR,0,0);
        for (int k = 0; k < 3; k++) begin
            v(0,0,6'd0,0,0,1,1,1,P1,0,WR,0,0);
            v(0,0,6'd0,0,0,1,1,1,P2,0,WR,0,0);
            v(0,0,6'd0,0,0,1,1,1,P3,0,WR,0,0);
            v(0,0,6'd0,0,(k == 2) ? 4'b0001 : 4'b0000,1,1,1,P4,0,WR,(k == 2),0);
        end
        v(0,0,6'd0 ,0,0,1,1,1,PI,0,WR,0,0);
        v(0,0,6'd0 ,0,0,0,1,1,PI,0,WR,0,0);
        // demand read ch1, request drops during 2nd transfer
        v(1,1,M_DRD,0,0,0,1,1,PI,1,RD,0,0);
        v(1,1,M_DRD,0,0,1,1,1,P0,1,RD,0,0);
        v(1,1,M_DRD,0,0,1,1,1,P1,1,RD,0,0);
        v(1,1,M_DRD,0,0,1,1,1,P2,1,RD,0,0);
        v(1,1,M_DRD,0,0,1,1,1,P3,1,RD,0,0);
        v(1,1,M_DRD,0,0,1,1,1,P4,1,RD,0,0);
        v(1,1,M_DRD,0,0,1,1,1,P1,1,RD,0,0);
        v(1,1,M_DRD,0,0,1,1,1,P2,1,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P3,1,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P4,1,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,PI,1,RD,0,0);
        // block read ch3: EOP in S2 ignored, EOP in 2nd S4 terminates
        v(1,3,M_BRD,0,0,0,1,1,PI,3,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P0,3,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P1,3,RD,0,0);
        v(0,0,6'd0 ,0,0,1,0,1,P2,3,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P3,3,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P4,3,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P1,3,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P2,3,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P3,3,RD,0,0);
        v(0,0,6'd0 ,0,0,1,0,1,P4,3,RD,1,0);
        v(0,0,6'd0 ,0,0,1,1,1,PI,3,RD,0,0);
        // block write ch1, HLDA drops in S4
        v(1,1,M_BWR,0,0,0,1,1,PI,1,WR,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P0,1,WR,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P1,1,WR,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P2,1,WR,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P3,1,WR,0,0);
        v(0,0,6'd0 ,0,0,0,1,1,P4,1,WR,0,0);
        v(0,0,6'd0 ,0,0,0,1,1,PI,1,WR,0,0);
        // cascade/verify ch3: single-like, no strobes
        v(1,3,M_CVF,0,0,0,1,1,PI,3,VF,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P0,3,VF,0,0);
        v(1,3,M_CVF,0,0,1,1,1,P1,3,VF,0,0);
        v(1,3,M_CVF,0,0,1,1,1,P2,3,VF,0,0);
        v(1,3,M_CVF,0,0,1,1,1,P3,3,VF,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P4,3,VF,0,0);
        v(0,0,6'd0 ,0,0,0,1,1,PI,3,VF,0,0);
        // controller disable: blocks start, and aborts from S0
        v(1,0,M_SWR,1,0,0,1,1,PI,0,WR,0,0);
        v(1,0,M_SWR,0,0,0,1,1,PI,0,WR,0,0);
        v(0,0,6'd0 ,1,0,0,1,1,P0,0,WR,0,0);
        v(0,0,6'd0 ,0,0,0,1,1,PI,0,WR,0,0);
        // async reset in S3
        v(1,2,M_SRD,0,0,0,1,1,PI,2,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P0,2,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P1,2,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P2,2,RD,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,PI,2,RD,0,1);
        v(0,0,6'd0 ,0,0,1,1,1,PI,2,RD,0,0);
        v(0,0,6'd0 ,0,0,0,1,1,PI,2,RD,0,0);
        // READY low for two cycles from S3
        v(1,1,M_SWR,0,0,0,1,1,PI,1,WR,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P0,1,WR,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P1,1,WR,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,P2,1,WR,0,0);
        v(0,0,6'd0 ,0,0,1,1,0,P3,1,WR,0,0);
`ifdef DMA_SEQ_READY_EN
        v(0,0,6'd0 ,0,0,1,1,0,PW,1,WR,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,PW,1,WR,0,0);
`endif
        v(0,0,6'd0 ,0,0,1,1,0,P4,1,WR,0,0);
        v(0,0,6'd0 ,0,0,1,1,1,PI,1,WR,0,0);

        // reset state
        repeat (2) @(posedge Clock);
        s.e = expv(PI, 2'd0, VF, 1'b0); s.idx = -1;
        sb.push_back(s);
        @(negedge Clock);
        check_pop(actual());
        #1 Reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge Clock);
            #1;
            ReqValid   = tbl[i].rv;
            ReqChannel = tbl[i].rch;
            ModeIn     = tbl[i].mode;
            CommandIn  = {5'b0, tbl[i].dis, 2'b0};
            TWCZero    = tbl[i].twcz;
            HLDA       = tbl[i].hlda;
            EOP_n      = tbl[i].eop_n;
            READY      = tbl[i].rdy;
            s.e = expv(tbl[i].ph, tbl[i].ech, tbl[i].ety, tbl[i].tc); s.idx = i;
            sb.push_back(s);
            if (tbl[i].rst) #1 Reset_n = 1'b0;
            @(negedge Clock);
            check_pop(actual());
            if (tbl[i].rst) #1 Reset_n = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_transfer_sequencer.md
Name: dma_transfer_sequencer

Overview:
Timing/control state machine that sequences one DMA transfer cycle at a time through the channel register banks. Takes the winning request from the priority block and runs the HRQ/HLDA bus handshake. Drives address strobe, DACK, and read/write strobes, and issues the per-channel enable/load pulses that step the temporary address and word-count registers. Sits between the priority block, the system bus pins and the datapath control interface.

Parameters:
NCH, 4, number of channels (DACK and per-channel control vector width)

Ports:
Clock  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
ReqValid  in  1  priority block has a granted, unmasked request
ReqChannel  in  2  channel number of granted request
ModeIn  in  6  mode register of ReqChannel: [5:4] mode (00 demand, 01 single, 10 block, 11 cascade→treated as single), [1:0] type (01 write, 10 read, 00/11 verify)
CommandIn  in  8  command register; bit 2 = controller disable
TWCZero  in  NCH  per-channel temp word count == 0
HLDA  in  1  hold acknowledge from CPU
READY  in  1  slow-device ready (used only with optional feature)
EOP_n  in  1  external end-of-process, active low
HRQ  out  1  hold request
AEN  out  1  address enable
ADSTB  out  1  upper-address strobe
DACK  out  NCH  one-hot channel acknowledge
MEMR_n, MEMW_n, IOR_n, IOW_n  out  1 each  bus strobes, active low
TAREnable  out  NCH  drive TAR onto address/data
TARLoad  out  NCH  one-cycle pulse, TAR <= inc/dec output
TWCLoad  out  NCH  one-cycle pulse, TWC <= decrementor output
RollOverCheck  out  NCH  one-cycle pulse, arms TC detect
TCOut  out  1  one-cycle terminal-count pulse
Busy  out  1  state != SI

Behaviour:
- Reset (async, Reset_n=0): state SI, all active-high outputs 0, all *_n strobes 1. Reset mid-transfer aborts immediately; no load pulses are issued.
- States: SI, S0, S1, S2, S3, S4 (plus SW with optional feature). One state per clock.
- SI: if ReqValid && !CommandIn[2], latch ch=ReqChannel and mode=ModeIn, then go to S0. Otherwise stay in SI.
- S0: HRQ=1. HLDA=1 → S1. CommandIn[2]=1 → SI with HRQ=0 next cycle. Otherwise stay in S0.
- S1: AEN=1, ADSTB=1, TAREnable[ch]=1.
- S2: ADSTB=0, AEN=1, DACK[ch]=1, TAREnable[ch]=1. Read strobe asserted: MEMR_n=0 for read type, IOR_n=0 for write type.
- S3: read strobe held; write strobe asserted: IOW_n=0 for read type, MEMW_n=0 for write type. Verify type asserts no strobes in any state.
- S4: all strobes high. TARLoad[ch], TWCLoad[ch], RollOverCheck[ch] pulse for exactly one cycle. tc = TWCZero[ch] (sampled before decrement) || !EOP_n. If tc, TCOut pulses.
- Exit from S4:
  - tc → SI.
  - single → SI.
  - block → S1.
  - demand → S1 if ReqValid && ReqChannel==ch, else SI.
  - HLDA=0 → SI, overriding the cases above.
- HRQ stays high from S0 through S4; it drops the cycle after returning to SI.
- DACK and AEN fall on entry to SI.
- Latched ch/mode are stable for the whole service; input changes are ignored until SI.
- Minimum transfer: 4 clocks (S1..S4) after HLDA.
- Only one bit of any NCH-wide output is ever set.
- EOP_n is sampled only in S4. An assertion in any other state is ignored unless it is still low at S4.
- Mode[3] (inc/dec) and Mode[2] (autoinit) are consumed by the datapath, not here.

Optional Feature:
Macro DMA_SEQ_READY_EN.
- Defined: READY is sampled in S3. READY=0 → SW; strobes, DACK, AEN and TAREnable are held at their S3 values. Stay in SW while READY=0; READY=1 → S4.
- Not defined: READY is ignored, S3 always goes to S4, and SW does not exist.

Test Plan:
- Single read, ch2, ModeIn=6'b01_0010, TWCZero=0, HLDA one cycle after HRQ → SI,S0,S1..S4,SI. MEMR_n low in S2-S3, IOW_n low in S3 only. DACK=4'b0100. One TARLoad[2]/TWCLoad[2] pulse. TCOut=0.
- Block write, ch0, TWCZero[0] rising on the 3rd S4 → three S1-S4 loops, MEMW_n/IOR_n per loop, TCOut pulses once in the 3rd S4, then SI and HRQ low.
- Demand mode, ch1: ReqValid drops during the 2nd transfer → exit to SI after that S4. Exactly 2 load pulses.
- EOP_n=0 in S4 of block transfer, ch3 → TCOut=1 that cycle, return to SI. EOP_n=0 pulsed only in S2 → no termination.
- CommandIn[2]=1 in S0, and separately Reset_n=0 in S3 → SI, HRQ=0, all strobes 1. No TARLoad pulse in either case.
- With DMA_SEQ_READY_EN, READY=0 for 2 cycles in S3 → two SW cycles with strobes held, then S4. Without the macro, same stimulus gives no stall.
